alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters: requester 0 and requester 1, e.g. an issue stage and a debug/self-test port.
- Arbitrates round-robin and uses a valid/ready handshake on both the request and response sides.
- Registers the operands and opcode and drives them into the ALU.
- Waits the ALU's pipeline latency, captures Result/Zero, and returns them to the granted requester.
- Only one operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width; matches the ALU.
- ALU_LATENCY, 1, number of register stages inside the ALU between A/B/AluOpCode and Result/Zero; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock; the ALU shares this clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid0  input  1  requester 0 has an operation.
- req_ready0  output  1  requester 0 operation accepted this cycle.
- req_a0  input  WIDTH  requester 0 operand A.
- req_b0  input  WIDTH  requester 0 operand B.
- req_op0  input  4  requester 0 AluOpCode.
- rsp_valid0  output  1  result for requester 0 available.
- rsp_ready0  input  1  requester 0 consumes the result.
- req_valid1, req_ready1, req_a1, req_b1, req_op1, rsp_valid1, rsp_ready1: same as the requester 0 ports, for requester 1.
- rsp_result  output  WIDTH  captured ALU Result; shared, qualified by rsp_valid0/1.
- rsp_zero  output  1  captured ALU Zero.
- alu_a  output  WIDTH  to ALU input A.
- alu_b  output  WIDTH  to ALU input B.
- alu_op  output  4  to ALU AluOpCode.
- alu_result  input  WIDTH  from ALU Result.
- alu_zero  input  1  from ALU Zero.
- busy  output  1  high in EXEC or DONE.
- grant_id  output  1  requester owning the current or last operation.

Behaviour:
Reset (rst_n low, any time, including mid-operation):
- State goes to IDLE immediately.
- alu_a, alu_b, alu_op, rsp_result, rsp_zero, grant_id, the latency counter and all rsp_valid outputs are cleared to 0.
- last_grant is set to 1, so requester 0 wins the first contention.
- An in-flight operation is discarded; no response is produced for it.

State machine, IDLE / EXEC / DONE:
- IDLE:
  - Grant selection: if only one req_valid is high, that requester is granted. If both are high, the requester != last_grant is granted.
  - req_readyX is combinational and is high only in IDLE, only for the granted X, and only while req_validX is high.
  - At most one req_ready is high in any cycle.
  - Transfer edge E, when req_validX && req_readyX:
    - register req_aX, req_bX and req_opX onto alu_a, alu_b and alu_op;
    - set grant_id = X and last_grant = X;
    - load the counter with ALU_LATENCY;
    - go to EXEC.
- EXEC:
  - alu_a, alu_b and alu_op are held stable.
  - While the counter is nonzero, decrement it each cycle.
  - On the edge where the counter is 0, which is edge E+1+ALU_LATENCY:
    - capture alu_result into rsp_result and alu_zero into rsp_zero;
    - go to DONE.
  - Requests are ignored in this state (all req_ready low).
- DONE:
  - rsp_valid[grant_id] is high, and the other rsp_valid is low.
  - rsp_result and rsp_zero are stable until the handshake.
  - On rsp_valid && rsp_ready, go to IDLE at that edge and drop rsp_valid.
  - If rsp_ready stays low, hold indefinitely in DONE, which applies backpressure.

Timing:
- Minimum turnaround is accept at E, rsp_valid from E+1+L, IDLE after E+2+L, next accept at E+3+L (L = ALU_LATENCY).
- Throughput is therefore one operation per L+3 cycles.

Other rules:
- alu_* hold their last values in IDLE and DONE; they change only at a transfer edge.
- Opcodes pass through unmodified; all 16 encodings are accepted.
- A requester that holds req_valid while its own result is pending sees req_ready low until the next IDLE.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1,...
- Protocol: req_valid and the request payload must stay stable until accepted. The block does not check this.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs -> all outputs 0 and busy=0. Release, then raise req_valid0 and req_valid1 together -> req_ready0=1 and req_ready1=0 in the same cycle.
- Single op, L=1: req0 with A=0xF0F0_0000, B=0xFF00_0000, op=4'b0100 (AND), accepted at edge E, rsp_ready0=1 -> rsp_valid0 rises after E+2 with rsp_result=0xF000_0000 and rsp_zero matching the ALU; IDLE after E+3.
- Contention and fairness: both requesters valid for 4 operations, op=4'b0101 (OR) with A=0x1, B=0x2 -> grants 0,1,0,1 and four responses of 0x3 on the correct rsp_valid lines; never both rsp_valid high.
- Backpressure: complete an op with rsp_ready1=0 for 10 cycles -> rsp_valid1, rsp_result and rsp_zero stable for all 10 cycles; req_ready0 stays low despite req_valid0=1; requester 0 is accepted in the first IDLE cycle after rsp_ready1=1.
- Reset mid-operation: assert rst_n=0 during EXEC -> immediate IDLE with outputs 0 and no rsp_valid afterwards; the next request returns the correct result.
- Latency sweep: ALU_LATENCY=0 and ALU_LATENCY=3 with a matching ALU model, op=4'b0110 (XOR) with A=0xFFFF_FFFF, B=0x0000_FFFF -> rsp_result=0xFFFF_0000 captured exactly at edge E+1+L.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one pipelined ALU between two requesters
// One operation in flight: IDLE accepts, EXEC waits out the ALU latency, DONE holds the response.
module alu_arbiter #(
  parameter int WIDTH       = 32,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid0,
  output logic             req_ready0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [3:0]       req_op0,
  output logic             rsp_valid0,
  input  logic             rsp_ready0,
  input  logic             req_valid1,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [3:0]       req_op1,
  output logic             rsp_valid1,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic             grant_id
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic             r_last_grant;
  logic             r_grant_id;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_op;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;

  logic w_idle;
  logic w_sel;
  logic w_accept;
  logic w_rsp_done;

  // Requester 1 wins when alone, or under contention when requester 0 went last.
  assign w_idle     = (r_state == S_IDLE);
  assign w_sel      = req_valid1 && (!req_valid0 || !r_last_grant);
  assign req_ready0 = rst_n && w_idle && req_valid0 && !w_sel;
  assign req_ready1 = rst_n && w_idle && req_valid1 && w_sel;
  assign w_accept   = req_ready0 || req_ready1;

  assign rsp_valid0 = (r_state == S_DONE) && !r_grant_id;
  assign rsp_valid1 = (r_state == S_DONE) && r_grant_id;
  assign w_rsp_done = (rsp_valid0 && rsp_ready0) || (rsp_valid1 && rsp_ready1);

  assign busy       = !w_idle;
  assign grant_id   = r_grant_id;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state      <= S_EXEC;
            r_cnt        <= 4'(ALU_LATENCY);
            r_grant_id   <= w_sel;
            r_last_grant <= w_sel;
          end
        end
        S_EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_rsp_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operands only move at a transfer edge; the result only at the final EXEC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= 4'd0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a  <= w_sel ? req_a1 : req_a0;
        r_alu_b  <= w_sel ? req_b1 : req_b0;
        r_alu_op <= w_sel ? req_op1 : req_op0;
      end
      if (r_state == S_EXEC && r_cnt == 4'd0) begin
        r_rsp_result <= alu_result;
        r_rsp_zero   <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter at latencies 0, 1 and 3
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_valid0, req_valid1, rsp_ready0, rsp_ready1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_op0, req_op1;

  logic        rdy0_l1, rdy1_l1, vld0_l1, vld1_l1, zero_l1, busy_l1, gid_l1, az_l1;
  logic [31:0] res_l1, a_l1, b_l1, ar_l1;
  logic [3:0]  op_l1;
  logic        rdy0_l0, rdy1_l0, vld0_l0, vld1_l0, zero_l0, busy_l0, gid_l0, az_l0;
  logic [31:0] res_l0, a_l0, b_l0, ar_l0;
  logic [3:0]  op_l0;
  logic        rdy0_l3, rdy1_l3, vld0_l3, vld1_l3, zero_l3, busy_l3, gid_l3, az_l3;
  logic [31:0] res_l3, a_l3, b_l3, ar_l3;
  logic [3:0]  op_l3;
  logic [31:0] pipe_l3 [3];

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'b0000: alu_f = a + b;
      4'b0001: alu_f = a - b;
      4'b0100: alu_f = a & b;
      4'b0101: alu_f = a | b;
      4'b0110: alu_f = a ^ b;
      default: alu_f = a;
    endcase
  endfunction

  // Reference ALUs with 0, 1 and 3 register stages
  assign ar_l0 = alu_f(a_l0, b_l0, op_l0);
  assign az_l0 = (ar_l0 == 32'd0);
  always @(posedge clk) ar_l1 <= alu_f(a_l1, b_l1, op_l1);
  assign az_l1 = (ar_l1 == 32'd0);
  always @(posedge clk) begin
    pipe_l3[0] <= alu_f(a_l3, b_l3, op_l3);
    pipe_l3[1] <= pipe_l3[0];
    pipe_l3[2] <= pipe_l3[1];
  end
  assign ar_l3 = pipe_l3[2];
  assign az_l3 = (ar_l3 == 32'd0);

  alu_arbiter #(.WIDTH(32), .ALU_LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid0), .req_ready0(rdy0_l1), .req_a0(req_a0), .req_b0(req_b0),
    .req_op0(req_op0), .rsp_valid0(vld0_l1), .rsp_ready0(rsp_ready0),
    .req_valid1(req_valid1), .req_ready1(rdy1_l1), .req_a1(req_a1), .req_b1(req_b1),
    .req_op1(req_op1), .rsp_valid1(vld1_l1), .rsp_ready1(rsp_ready1),
    .rsp_result(res_l1), .rsp_zero(zero_l1), .alu_a(a_l1), .alu_b(b_l1), .alu_op(op_l1),
    .alu_result(ar_l1), .alu_zero(az_l1), .busy(busy_l1), .grant_id(gid_l1)
  );

  alu_arbiter #(.WIDTH(32), .ALU_LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid0), .req_ready0(rdy0_l0), .req_a0(req_a0), .req_b0(req_b0),
    .req_op0(req_op0), .rsp_valid0(vld0_l0), .rsp_ready0(rsp_ready0),
    .req_valid1(req_valid1), .req_ready1(rdy1_l0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op1(req_op1), .rsp_valid1(vld1_l0), .rsp_ready1(rsp_ready1),
    .rsp_result(res_l0), .rsp_zero(zero_l0), .alu_a(a_l0), .alu_b(b_l0), .alu_op(op_l0),
    .alu_result(ar_l0), .alu_zero(az_l0), .busy(busy_l0), .grant_id(gid_l0)
  );

  alu_arbiter #(.WIDTH(32), .ALU_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid0), .req_ready0(rdy0_l3), .req_a0(req_a0), .req_b0(req_b0),
    .req_op0(req_op0), .rsp_valid0(vld0_l3), .rsp_ready0(rsp_ready0),
    .req_valid1(req_valid1), .req_ready1(rdy1_l3), .req_a1(req_a1), .req_b1(req_b1),
    .req_op1(req_op1), .rsp_valid1(vld1_l3), .rsp_ready1(rsp_ready1),
    .rsp_result(res_l3), .rsp_zero(zero_l3), .alu_a(a_l3), .alu_b(b_l3), .alu_op(op_l3),
    .alu_result(ar_l3), .alu_zero(az_l3), .busy(busy_l3), .grant_id(gid_l3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(output int who);
    int n = 0;
    #1;
    while (!rdy0_l1 && !rdy1_l1 && n < 20) begin
      tick();
      n++;
    end
    chk("ready_timeout", 32'(n >= 20), 32'd0);
    who = rdy1_l1 ? 1 : 0;
  endtask

  task automatic wait_rsp(output int who);
    int n = 0;
    #1;
    while (!vld0_l1 && !vld1_l1 && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_timeout", 32'(n >= 20), 32'd0);
    who = vld1_l1 ? 1 : 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int who;
    int g;
    rst_n = 1'b0;
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    req_a0 = $urandom; req_b0 = $urandom; req_op0 = 4'($urandom);
    req_a1 = $urandom; req_b1 = $urandom; req_op1 = 4'($urandom);
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    tick();
    tick();
    chk("rst_alu_a", a_l1, 32'd0);
    chk("rst_alu_b", b_l1, 32'd0);
    chk("rst_alu_op", 32'(op_l1), 32'd0);
    chk("rst_result", res_l1, 32'd0);
    chk("rst_zero", 32'(zero_l1), 32'd0);
    chk("rst_grant", 32'(gid_l1), 32'd0);
    chk("rst_vld0", 32'(vld0_l1), 32'd0);
    chk("rst_vld1", 32'(vld1_l1), 32'd0);
    chk("rst_busy", 32'(busy_l1), 32'd0);
    chk("rst_rdy0", 32'(rdy0_l1), 32'd0);
    chk("rst_rdy1", 32'(rdy1_l1), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_contend_rdy0", 32'(rdy0_l1), 32'd1);
    chk("first_contend_rdy1", 32'(rdy1_l1), 32'd0);

    // Single AND op, L=1
    req_valid1 = 1'b0;
    req_a0 = 32'hF0F0_0000; req_b0 = 32'hFF00_0000; req_op0 = 4'b0100;
    tick();
    req_valid0 = 1'b0;
    #1;
    chk("single_busy", 32'(busy_l1), 32'd1);
    chk("single_alu_a", a_l1, 32'hF0F0_0000);
    chk("single_alu_b", b_l1, 32'hFF00_0000);
    chk("single_alu_op", 32'(op_l1), 32'h4);
    chk("single_grant", 32'(gid_l1), 32'd0);
    chk("single_vld_e0", 32'(vld0_l1), 32'd0);
    tick();
    chk("single_vld_e1", 32'(vld0_l1), 32'd0);
    tick();
    chk("single_vld_e2", 32'(vld0_l1), 32'd1);
    chk("single_vld1_e2", 32'(vld1_l1), 32'd0);
    chk("single_result", res_l1, 32'hF000_0000);
    chk("single_zero", 32'(zero_l1), 32'd0);
    tick();
    chk("single_idle_e3", 32'(busy_l1), 32'd0);
    chk("single_vld_e3", 32'(vld0_l1), 32'd0);
    chk("single_alu_hold", a_l1, 32'hF0F0_0000);

    // Contention: grants must alternate starting with requester 0
    do_reset();
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    req_a0 = 32'h1; req_b0 = 32'h2; req_op0 = 4'b0101;
    req_a1 = 32'h1; req_b1 = 32'h2; req_op1 = 4'b0101;
    g = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ready(who);
      chk("cont_grant", 32'(who), 32'(g));
      tick();
      wait_rsp(who);
      chk("cont_rsp_line", 32'(who), 32'(g));
      chk("cont_one_rsp", 32'(vld0_l1 & vld1_l1), 32'd0);
      chk("cont_result", res_l1, 32'h3);
      chk("cont_grant_id", 32'(gid_l1), 32'(g));
      if (i == 3) begin
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
      end
      tick();
      g = 1 - g;
    end

    // Backpressure on requester 1 while requester 0 waits
    req_valid1 = 1'b1; req_a1 = 32'h5; req_b1 = 32'h7; req_op1 = 4'b0000;
    rsp_ready1 = 1'b0;
    wait_ready(who);
    chk("bp_grant", 32'(who), 32'd1);
    tick();
    req_valid1 = 1'b0;
    req_valid0 = 1'b1; req_a0 = 32'h10; req_b0 = 32'h10; req_op0 = 4'b0001;
    wait_rsp(who);
    chk("bp_rsp_line", 32'(who), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld1", 32'(vld1_l1), 32'd1);
      chk("bp_result", res_l1, 32'hC);
      chk("bp_zero", 32'(zero_l1), 32'd0);
      chk("bp_rdy0_low", 32'(rdy0_l1), 32'd0);
      tick();
    end
    rsp_ready1 = 1'b1;
    tick();
    chk("bp_rdy0_first_idle", 32'(rdy0_l1), 32'd1);
    chk("bp_idle", 32'(busy_l1), 32'd0);
    tick();
    req_valid0 = 1'b0;
    wait_rsp(who);
    chk("bp_r0_line", 32'(who), 32'd0);
    chk("bp_r0_result", res_l1, 32'h0);
    chk("bp_r0_zero", 32'(zero_l1), 32'd1);
    tick();

    // Reset during EXEC discards the operation
    req_valid0 = 1'b1; req_a0 = 32'hA5; req_b0 = 32'h0F; req_op0 = 4'b0110;
    wait_ready(who);
    tick();
    req_valid0 = 1'b0;
    chk("mid_busy_before", 32'(busy_l1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy_l1), 32'd0);
    chk("mid_alu_a", a_l1, 32'd0);
    chk("mid_alu_op", 32'(op_l1), 32'd0);
    chk("mid_grant", 32'(gid_l1), 32'd0);
    chk("mid_vld0", 32'(vld0_l1), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_rsp", 32'(vld0_l1 | vld1_l1), 32'd0);
    end
    req_valid0 = 1'b1; req_a0 = 32'hFF; req_b0 = 32'h0F; req_op0 = 4'b0100;
    wait_ready(who);
    tick();
    req_valid0 = 1'b0;
    wait_rsp(who);
    chk("mid_next_line", 32'(who), 32'd0);
    chk("mid_next_result", res_l1, 32'h0F);
    tick();

    // Latency sweep: all three instances accept at the same edge
    do_reset();
    rsp_ready0 = 1'b0; rsp_ready1 = 1'b0; req_valid1 = 1'b0;
    req_valid0 = 1'b1; req_a0 = 32'hFFFF_FFFF; req_b0 = 32'h0000_FFFF; req_op0 = 4'b0110;
    #1;
    chk("sweep_rdy_l0", 32'(rdy0_l0), 32'd1);
    chk("sweep_rdy_l3", 32'(rdy0_l3), 32'd1);
    tick();
    req_valid0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("sweep_vld_l0", 32'(vld0_l0), 32'(k >= 1));
      chk("sweep_vld_l1", 32'(vld0_l1), 32'(k >= 2));
      chk("sweep_vld_l3", 32'(vld0_l3), 32'(k >= 4));
      if (k >= 1) chk("sweep_res_l0", res_l0, 32'hFFFF_0000);
      if (k >= 2) chk("sweep_res_l1", res_l1, 32'hFFFF_0000);
      if (k >= 4) chk("sweep_res_l3", res_l3, 32'hFFFF_0000);
    end
    rsp_ready0 = 1'b1;
    tick();
    chk("sweep_idle_l0", 32'(busy_l0), 32'd0);
    chk("sweep_idle_l3", 32'(busy_l3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
